load_store_unit: RTL and testbench
==================================

# load_store_unit

Processor-side initiator for the single-cycle MIPS data memory port. Accepts one load/store request at a time from the datapath and drives the memory's addr/data/size/we/re interface. Naturally aligned accesses are issued as a single memory operation; misaligned accesses are sequenced as multiple operations, since the memory rejects size code 2. Returns sign- or zero-extended load data and flags out-of-window accesses.

## Interface
- MEM_ADDR, 16'h1000, required value of address bits [31:16]; any byte outside this window is an error.
- clock  in  1  single clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; request accepted on the posedge where req_valid && req_ready.
- req_op  in  3  operation code: LB=0, LH=1, LW=2, LBU=3, LHU=4, SB=5, SH=6, SW=7.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  window violation; qualified by resp_valid.
- mem_addr  out  32  memory address; 0 when idle.
- mem_wdata  out  32  memory write data, right-justified.
- mem_rdata  in  32  memory read data, combinational from mem_addr.
- mem_size  out  2  0=byte, 1=half, 3=word; never drives 2.
- mem_we  out  1  write strobe; the write commits at the posedge ending the cycle.
- mem_re  out  1  read strobe.

## Operation
- Byte lanes are little-endian: byte at offset k of a word occupies bits [8k+7:8k].
- Access widths: n=1 for B/BU, 2 for H/HU, 4 for W. Offset k = addr[1:0].
- Error: addr[31:16] != MEM_ADDR or (addr+n-1)[31:16] != MEM_ADDR. On error, no memory access is made; the FSM goes directly to RESP with resp_err=1.
- FSM states: IDLE, ACCESS, ACCESS2, RESP.
- IDLE: req_ready=1. On accept, latch op, addr, and wdata, then go to ACCESS (or RESP on error).
- Load in ACCESS:
  - mem_re=1, mem_addr={addr[31:2],2'b00}, mem_size=3.
  - Latch word0.
  - If k+n>4, go to ACCESS2; otherwise go to RESP.
- Load in ACCESS2:
  - mem_addr=word0 address+4, mem_re=1.
  - result = ({mem_rdata,word0} >> 8k), truncated to n bytes.
  - Single-word case: result = word0 >> 8k.
  - Extension: LB and LH sign-extend; LBU and LHU zero-extend.
- Aligned store (SB any k; SH k∈{0,2}; SW k=0):
  - One ACCESS cycle with mem_we=1, mem_addr=addr, mem_size=0/1/3, mem_wdata=wdata.
  - Then RESP.
- Misaligned store:
  - n byte writes, one per ACCESS cycle, counter i=0..n-1.
  - Write i: mem_addr=addr+i, mem_size=0, mem_wdata={24'b0, wdata[8i+7:8i]}.
  - After i=n-1, go to RESP.
- RESP: resp_valid=1 for one cycle, then IDLE.
- Outside ACCESS/ACCESS2: mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, mem_size=3.
- mem_we and mem_re are gated by !reset.

## Timing
- Accept on edge of cycle T:
  - aligned or single-word access: resp_valid in T+2.
  - misaligned load spanning two words: T+3.
  - misaligned store: T+n+1.
  - error: T+1.
- req_ready=0 from T+1 until IDLE is re-entered; back-to-back requests are spaced by at least latency+1 cycles.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, all mem_* outputs 0 except mem_size=3.
- Reset mid-operation: during the reset cycle mem_we=0, so no byte commits on that edge. Bytes already written stay written. No response is produced for the aborted request. req_ready=1 in the first cycle after reset.
- Address arithmetic is 32-bit modulo. A wrap across the window boundary is caught by the error rule.

## Structure
- Package lsu_pkg: op encodings, size codes (SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=3), FSM state enum, and op_bytes()/op_is_store()/op_is_signed() helpers.
- Sub-module lsu_load_align: combinational shift and extend of {word1,word0} by k, n, and signedness.
- Top: FSM, counter, and latches.

## Test plan
- LW 0x10000010, memory word 0x11223344 -> one read, mem_size=3; resp_valid at T+2 with rdata 0x11223344, resp_err=0.
- LB / LBU 0x10000013, word 0x80FF0102 -> 0xFFFFFF80 / 0x00000080.
- LW 0x10000006, words 0x44332211 @0x..04 and 0x88776655 @0x..08 -> reads at 0x..04 then 0x..08; rdata 0x66554433 at T+3.
- SW 0x10000001, wdata 0xAABBCCDD, memory initially 0xADADADAD:
  - byte writes at 0x..01–0x..04 with data DD, CC, BB, AA; resp at T+5.
  - words then read back 0xBBCCDDAD and 0xADADADAA.
- SW 0x20000000, and LW 0x1000FFFE -> resp_err=1 at T+1; mem_we and mem_re never asserted.
- Reset asserted during the third byte of a misaligned SW -> mem_we=0 in that cycle, the first two bytes persist, no resp_valid, req_ready=1 the next cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: op codes, memory size
// codes, FSM states and small decode functions.
package lsu_pkg;

    // Upper half of every legal data address.
    localparam logic [15:0] MEM_ADDR = 16'h1000;

    // Memory size codes; code 2 is rejected by the memory and never driven.
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd3;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LH  = 3'd1,
        OP_LW  = 3'd2,
        OP_LBU = 3'd3,
        OP_LHU = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_ACCESS2 = 2'd2,
        ST_RESP    = 2'd3
    } lsu_state_e;

    // Access width in bytes (1, 2 or 4).
    function automatic logic [2:0] op_bytes(input lsu_op_e op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_bytes = 3'd1;
            OP_LH, OP_LHU, OP_SH: op_bytes = 3'd2;
            default:              op_bytes = 3'd4;
        endcase
    endfunction

    function automatic logic op_is_store(input lsu_op_e op);
        op_is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic op_is_signed(input lsu_op_e op);
        op_is_signed = (op == OP_LB) || (op == OP_LH);
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load alignment: picks n bytes starting at byte offset k out
// of the two-word window {word1, word0} and sign- or zero-extends them.
// Only the low three bytes of word1 can ever fall inside a 4-byte window.
module lsu_load_align (
    input  logic [23:0] word1,
    input  logic [31:0] word0,
    input  logic [1:0]  k,
    input  logic [2:0]  nbytes,
    input  logic        is_signed,
    output logic [31:0] result
);

    logic [31:0] shifted;

    // Shift the window right by k bytes, then truncate and extend to n bytes.
    always_comb begin
        case (k)
            2'd1:    shifted = {word1[7:0],  word0[31:8]};
            2'd2:    shifted = {word1[15:0], word0[31:16]};
            2'd3:    shifted = {word1[23:0], word0[31:24]};
            default: shifted = word0;
        endcase
        case (nbytes)
            3'd1:    result = {{24{is_signed & shifted[7]}},  shifted[7:0]};
            3'd2:    result = {{16{is_signed & shifted[15]}}, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, issues aligned accesses as
// a single memory operation, splits misaligned loads into two word reads and
// misaligned stores into byte writes, and returns extended load data.
module load_store_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  mem_size,
    output logic        mem_we,
    output logic        mem_re
);

    import lsu_pkg::*;

    lsu_state_e  state_q, state_d;
    lsu_op_e     op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word0_q, word0_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [1:0]  cnt_q, cnt_d;

    lsu_op_e     req_op_e;
    logic [2:0]  req_n;
    logic        req_err;
    logic [2:0]  n_q;
    logic [1:0]  k_q;
    logic        spans_two_words;
    logic        store_aligned;
    logic [1:0]  store_size;
    logic [31:0] word_addr;
    logic [31:0] align_word0;
    logic [31:0] load_result;
    logic        we_raw;
    logic        re_raw;

    assign req_op_e = lsu_op_e'(req_op);
    assign req_n    = op_bytes(req_op_e);
    // The first byte must be in the window and the last byte must not carry
    // out of its low 16 bits, which is the same as staying in the window.
    assign req_err  = (req_addr[31:16] != MEM_ADDR) ||
                      (req_addr[15:0] > (16'hFFFF - ({13'b0, req_n} - 16'd1)));

    assign n_q             = op_bytes(op_q);
    assign k_q             = addr_q[1:0];
    assign spans_two_words = ({2'b00, k_q} + {1'b0, n_q}) > 4'd4;
    assign word_addr       = {addr_q[31:2], 2'b00};
    assign align_word0     = (state_q == ST_ACCESS2) ? word0_q : mem_rdata;

    // Classify the latched store as single-operation or byte-by-byte.
    always_comb begin
        case (op_q)
            OP_SB: begin
                store_aligned = 1'b1;
                store_size    = SIZE_BYTE;
            end
            OP_SH: begin
                store_aligned = ~k_q[0];
                store_size    = SIZE_HALF;
            end
            default: begin
                store_aligned = (k_q == 2'd0);
                store_size    = SIZE_WORD;
            end
        endcase
    end

    lsu_load_align u_align (
        .word1     (mem_rdata[23:0]),
        .word0     (align_word0),
        .k         (k_q),
        .nbytes    (n_q),
        .is_signed (op_is_signed(op_q)),
        .result    (load_result)
    );

    // Next-state, datapath latches and memory/response outputs.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        word0_d    = word0_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'd0;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        mem_size   = SIZE_WORD;
        we_raw     = 1'b0;
        re_raw     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d    = req_op_e;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = 2'd0;
                    rdata_d = 32'd0;
                    err_d   = req_err;
                    state_d = req_err ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (op_is_store(op_q)) begin
                    we_raw = 1'b1;
                    if (store_aligned) begin
                        mem_addr  = addr_q;
                        mem_size  = store_size;
                        mem_wdata = wdata_q;
                        state_d   = ST_RESP;
                    end else begin
                        mem_addr  = addr_q + {30'd0, cnt_q};
                        mem_size  = SIZE_BYTE;
                        mem_wdata = {24'd0, wdata_q[{cnt_q, 3'b000} +: 8]};
                        cnt_d     = cnt_q + 2'd1;
                        if ({1'b0, cnt_q} == (n_q - 3'd1)) begin
                            state_d = ST_RESP;
                        end
                    end
                end else begin
                    re_raw   = 1'b1;
                    mem_addr = word_addr;
                    word0_d  = mem_rdata;
                    if (spans_two_words) begin
                        state_d = ST_ACCESS2;
                    end else begin
                        rdata_d = load_result;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ACCESS2: begin
                re_raw   = 1'b1;
                mem_addr = word_addr + 32'd4;
                rdata_d  = load_result;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = rdata_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        mem_we = we_raw & ~reset;
        mem_re = re_raw & ~reset;
    end

    // State and latch registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LB;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            word0_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word0_q <= word0_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a behavioural
// byte-addressable data memory and an access monitor.
module tb_load_store_unit;

    import lsu_pkg::*;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_size;
    logic        mem_we;
    logic        mem_re;

    load_store_unit dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_size   (mem_size),
        .mem_we     (mem_we),
        .mem_re     (mem_re)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Data memory covering the 64 KiB window; reads are combinational.
    logic [31:0] tb_mem [16384];
    assign mem_rdata = tb_mem[mem_addr[15:2]];

    // Writes commit on the posedge ending a cycle with mem_we high.
    always @(posedge clock) begin
        if (mem_we) begin
            case (mem_size)
                2'd0:    tb_mem[mem_addr[15:2]][{mem_addr[1:0], 3'b000} +: 8]  <= mem_wdata[7:0];
                2'd1:    tb_mem[mem_addr[15:2]][{mem_addr[1:0], 3'b000} +: 16] <= mem_wdata[15:0];
                default: tb_mem[mem_addr[15:2]] <= mem_wdata;
            endcase
        end
    end

    // Access log sampled mid-cycle.
    int          n_reads = 0;
    int          n_writes = 0;
    int          bad_size = 0;
    logic [31:0] acc_addr [$];
    logic [1:0]  acc_size [$];

    always @(negedge clock) begin
        if (mem_re) n_reads++;
        if (mem_we) n_writes++;
        if (mem_we || mem_re) begin
            acc_addr.push_back(mem_addr);
            acc_size.push_back(mem_size);
            if (mem_size == 2'd2) bad_size++;
        end
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pre0;
        logic [31:0] pre1;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_reads;
        int          exp_writes;
        logic [31:0] exp_first_addr;
        logic [1:0]  exp_first_size;
        logic [31:0] exp_w0;
        logic [31:0] exp_w1;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;

    int          act_lat;
    logic        act_ready1;
    logic [31:0] act_rdata;
    logic        act_err;
    logic        act_after_valid;
    logic        act_after_ready;
    int          act_reads;
    int          act_writes;
    logic [31:0] act_first_addr;
    logic [1:0]  act_first_size;
    logic [31:0] act_w0;
    logic [31:0] act_w1;

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] pre0,
                                input logic [31:0] pre1, input logic [31:0] rdata,
                                input logic err, input int lat, input int rd,
                                input int wr, input logic [31:0] fa,
                                input logic [1:0] fs, input logic [31:0] w0,
                                input logic [31:0] w1);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.pre0 = pre0; v.pre1 = pre1;
        v.exp_rdata = rdata; v.exp_err = err; v.exp_lat = lat;
        v.exp_reads = rd; v.exp_writes = wr;
        v.exp_first_addr = fa; v.exp_first_size = fs;
        v.exp_w0 = w0; v.exp_w1 = w1;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s vec%0d actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    // Preload the two words around the address, issue one request, and
    // capture latency, response and memory side effects.
    task automatic applyStimulus(input vec_t v);
        logic [13:0] i0;
        logic [13:0] i1;
        int r0, w0, a0;
        i0 = v.addr[15:2];
        i1 = i0 + 14'd1;
        tb_mem[i0] = v.pre0;
        tb_mem[i1] = v.pre1;
        r0 = n_reads;
        w0 = n_writes;
        a0 = acc_addr.size();
        @(negedge clock);
        req_valid = 1'b1;
        req_op    = v.op;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(posedge clock);
        #1 req_valid = 1'b0;
        act_lat    = -1;
        act_ready1 = 1'b1;
        act_rdata  = 32'hDEAD_BEEF;
        act_err    = 1'bx;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (c == 1) act_ready1 = req_ready;
            if (resp_valid) begin
                act_lat   = c;
                act_rdata = resp_rdata;
                act_err   = resp_err;
                break;
            end
        end
        @(negedge clock);
        act_after_valid = resp_valid;
        act_after_ready = req_ready;
        for (int c = 0; c < 40 && !req_ready; c++) @(negedge clock);
        act_reads  = n_reads - r0;
        act_writes = n_writes - w0;
        act_first_addr = (acc_addr.size() > a0) ? acc_addr[a0] : 32'd0;
        act_first_size = (acc_size.size() > a0) ? acc_size[a0] : 2'd3;
        act_w0 = tb_mem[i0];
        act_w1 = tb_mem[i1];
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) tb_mem[i] = 32'd0;

        //              op      addr          wdata         pre0          pre1          rdata         err lat rd wr first_addr    sz    w0            w1
        vecs[0]  = mk(OP_LW,  32'h1000_0010, 32'h0,        32'h1122_3344, 32'h0,        32'h1122_3344, 0, 2, 1, 0, 32'h1000_0010, 2'd3, 32'h1122_3344, 32'h0);
        vecs[1]  = mk(OP_LB,  32'h1000_0013, 32'h0,        32'h80FF_0102, 32'h0,        32'hFFFF_FF80, 0, 2, 1, 0, 32'h1000_0010, 2'd3, 32'h80FF_0102, 32'h0);
        vecs[2]  = mk(OP_LBU, 32'h1000_0013, 32'h0,        32'h80FF_0102, 32'h0,        32'h0000_0080, 0, 2, 1, 0, 32'h1000_0010, 2'd3, 32'h80FF_0102, 32'h0);
        vecs[3]  = mk(OP_LW,  32'h1000_0006, 32'h0,        32'h4433_2211, 32'h8877_6655, 32'h6655_4433, 0, 3, 2, 0, 32'h1000_0004, 2'd3, 32'h4433_2211, 32'h8877_6655);
        vecs[4]  = mk(OP_LH,  32'h1000_0003, 32'h0,        32'hAB00_0000, 32'h0000_00CD, 32'hFFFF_CDAB, 0, 3, 2, 0, 32'h1000_0000, 2'd3, 32'hAB00_0000, 32'h0000_00CD);
        vecs[5]  = mk(OP_LHU, 32'h1000_0012, 32'h0,        32'h80FF_0102, 32'h0,        32'h0000_80FF, 0, 2, 1, 0, 32'h1000_0010, 2'd3, 32'h80FF_0102, 32'h0);
        vecs[6]  = mk(OP_LH,  32'h1000_0012, 32'h0,        32'h80FF_0102, 32'h0,        32'hFFFF_80FF, 0, 2, 1, 0, 32'h1000_0010, 2'd3, 32'h80FF_0102, 32'h0);
        vecs[7]  = mk(OP_LB,  32'h1000_FFFF, 32'h0,        32'h7F00_0000, 32'h0,        32'h0000_007F, 0, 2, 1, 0, 32'h1000_FFFC, 2'd3, 32'h7F00_0000, 32'h0);
        vecs[8]  = mk(OP_SW,  32'h2000_0000, 32'h1234_5678, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 32'h0,       1, 1, 0, 0, 32'h0,        2'd3, 32'h5A5A_5A5A, 32'h5A5A_5A5A);
        vecs[9]  = mk(OP_LW,  32'h1000_FFFE, 32'h0,        32'h1234_5678, 32'h9ABC_DEF0, 32'h0,        1, 1, 0, 0, 32'h0,        2'd3, 32'h1234_5678, 32'h9ABC_DEF0);
        vecs[10] = mk(OP_LH,  32'h0FFF_FFFF, 32'h0,        32'h0,        32'h0,        32'h0,        1, 1, 0, 0, 32'h0,        2'd3, 32'h0,        32'h0);
        vecs[11] = mk(OP_SW,  32'h1000_0001, 32'hAABB_CCDD, 32'hADAD_ADAD, 32'hADAD_ADAD, 32'h0,       0, 5, 0, 4, 32'h1000_0001, 2'd0, 32'hBBCC_DDAD, 32'hADAD_ADAA);
        vecs[12] = mk(OP_SW,  32'h1000_0050, 32'hCAFE_F00D, 32'h0,        32'h0,        32'h0,        0, 2, 0, 1, 32'h1000_0050, 2'd3, 32'hCAFE_F00D, 32'h0);
        vecs[13] = mk(OP_SH,  32'h1000_0022, 32'h1234_BEEF, 32'h0,        32'h0,        32'h0,        0, 2, 0, 1, 32'h1000_0022, 2'd1, 32'hBEEF_0000, 32'h0);
        vecs[14] = mk(OP_SH,  32'h1000_0023, 32'h0000_BEEF, 32'h1111_1111, 32'h1111_1111, 32'h0,       0, 3, 0, 2, 32'h1000_0023, 2'd0, 32'hEF11_1111, 32'h1111_11BE);
        vecs[15] = mk(OP_SB,  32'h1000_0031, 32'hFFFF_FF5A, 32'h0,        32'h0,        32'h0,        0, 2, 0, 1, 32'h1000_0031, 2'd0, 32'h0000_5A00, 32'h0);
        vecs[16] = mk(OP_LW,  32'h1000_FFFD, 32'h0,        32'h0,        32'h0,        32'h0,        1, 1, 0, 0, 32'h0,        2'd3, 32'h0,        32'h0);
        vecs[17] = mk(OP_LH,  32'h1000_FFFE, 32'h0,        32'h8001_1234, 32'h0,        32'hFFFF_8001, 0, 2, 1, 0, 32'h1000_FFFC, 2'd3, 32'h8001_1234, 32'h0);

        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checkOutput("reset_req_ready",  -1, {31'd0, req_ready},  32'd1);
        checkOutput("reset_resp_valid", -1, {31'd0, resp_valid}, 32'd0);
        checkOutput("reset_resp_err",   -1, {31'd0, resp_err},   32'd0);
        checkOutput("reset_resp_rdata", -1, resp_rdata,          32'd0);
        checkOutput("reset_mem_addr",   -1, mem_addr,            32'd0);
        checkOutput("reset_mem_wdata",  -1, mem_wdata,           32'd0);
        checkOutput("reset_mem_size",   -1, {30'd0, mem_size},   32'd3);
        checkOutput("reset_mem_we",     -1, {31'd0, mem_we},     32'd0);
        checkOutput("reset_mem_re",     -1, {31'd0, mem_re},     32'd0);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            checkOutput("latency",     i, 32'(act_lat),             32'(vecs[i].exp_lat));
            checkOutput("ready_low",   i, {31'd0, act_ready1},      32'd0);
            checkOutput("rdata",       i, act_rdata,                vecs[i].exp_rdata);
            checkOutput("err",         i, {31'd0, act_err},         {31'd0, vecs[i].exp_err});
            checkOutput("pulse_end",   i, {31'd0, act_after_valid}, 32'd0);
            checkOutput("ready_back",  i, {31'd0, act_after_ready}, 32'd1);
            checkOutput("reads",       i, 32'(act_reads),           32'(vecs[i].exp_reads));
            checkOutput("writes",      i, 32'(act_writes),          32'(vecs[i].exp_writes));
            checkOutput("first_addr",  i, act_first_addr,           vecs[i].exp_first_addr);
            checkOutput("first_size",  i, {30'd0, act_first_size},  {30'd0, vecs[i].exp_first_size});
            checkOutput("mem_word0",   i, act_w0,                   vecs[i].exp_w0);
            checkOutput("mem_word1",   i, act_w1,                   vecs[i].exp_w1);
        end

        // Reset during the third byte write of a misaligned SW.
        begin
            int seen_resp;
            tb_mem[16] = 32'd0;
            tb_mem[17] = 32'd0;
            @(negedge clock);
            req_valid = 1'b1;
            req_op    = OP_SW;
            req_addr  = 32'h1000_0041;
            req_wdata = 32'h4433_2211;
            @(posedge clock);
            #1 req_valid = 1'b0;
            @(posedge clock);
            @(posedge clock);
            #1 reset = 1'b1;
            @(negedge clock);
            checkOutput("rst_mid_we", 100, {31'd0, mem_we}, 32'd0);
            @(posedge clock);
            #1 reset = 1'b0;
            @(negedge clock);
            checkOutput("rst_mid_ready", 100, {31'd0, req_ready}, 32'd1);
            seen_resp = (resp_valid === 1'b1) ? 1 : 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clock);
                if (resp_valid === 1'b1) seen_resp++;
            end
            checkOutput("rst_mid_no_resp", 100, 32'(seen_resp), 32'd0);
            checkOutput("rst_mid_word0",   100, tb_mem[16], 32'h0022_1100);
            checkOutput("rst_mid_word1",   100, tb_mem[17], 32'h0000_0000);
        end

        // Normal operation resumes after the aborted request.
        applyStimulus(vecs[0]);
        checkOutput("post_rst_latency", 101, 32'(act_lat), 32'd2);
        checkOutput("post_rst_rdata",   101, act_rdata,    32'h1122_3344);

        checkOutput("size_never_2", 102, 32'(bad_size), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
